// File: rtl/gfx_cmd_issuer.sv
// gfx_cmd_issuer: turns 48-bit command words into Wishbone register writes and GFX_STATUS busy polls
module gfx_cmd_issuer #(
  parameter int POLL_GAP = 8,
  parameter int TIMEOUT  = 4096
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [47:0] cmd_i,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [7:0]  adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  input  logic        ack_i,
  input  logic [31:0] dat_i,
  output logic        busy_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);
  localparam logic [7:0] OP_WR   = 8'h01;
  localparam logic [7:0] OP_WAIT = 8'h02;
  localparam logic [7:0] OP_DRAW = 8'h03;
  typedef enum logic [1:0] {IDLE, WRITE, GAP, POLL} state_t;
  state_t      state_q, state_d;
  logic [47:0] cmd_q, cmd_d;
  logic [15:0] poll_cnt_q, poll_cnt_d, gap_cnt_q, gap_cnt_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d, fault;
  logic        accept, is_draw, unused_dat;
  assign unused_dat  = ^dat_i[31:1];
  assign cmd_ready_o = state_q == IDLE && !rst_i;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign is_draw     = cmd_q[47:40] == OP_DRAW;
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    fault      = 2'd0;
    case (state_q)
      IDLE: if (accept) begin
        cmd_d      = cmd_i;
        poll_cnt_d = '0;
        if (cmd_i[47:40] == OP_WR) begin
          if (cmd_i[33:32] != 2'd0) fault = 2'd2;
          else state_d = WRITE;
        end else if (cmd_i[47:40] == OP_DRAW) state_d = WRITE;
        else if (cmd_i[47:40] == OP_WAIT) state_d = POLL;
        else fault = 2'd1;
      end
      // DRAW must not sample busy in the ack cycle, so it always waits out a gap first
      WRITE: if (ack_i) begin
        state_d   = is_draw ? GAP : IDLE;
        gap_cnt_d = '0;
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 16'd1;
        if (gap_cnt_q == 16'(POLL_GAP - 1)) state_d = POLL;
      end
      POLL: if (ack_i) begin
        poll_cnt_d = poll_cnt_q + 16'd1;
        gap_cnt_d  = '0;
        if (!dat_i[0]) state_d = IDLE;
        else if (poll_cnt_d == 16'(TIMEOUT)) begin
          fault   = 2'd3;
          state_d = IDLE;
        end else state_d = GAP;
      end
      default: state_d = IDLE;
    endcase
    err_d  = err_q || fault != 2'd0;
    code_d = code_q == 2'd0 ? fault : code_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
      err_q      <= 1'b0;
      code_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end
  assign cyc_o      = state_q == WRITE || state_q == POLL;
  assign stb_o      = cyc_o;
  assign we_o       = state_q == WRITE;
  assign sel_o      = cyc_o ? 4'hF : 4'h0;
  assign adr_o      = we_o ? (is_draw ? 8'h00 : cmd_q[39:32]) : state_q == POLL ? 8'h04 : 8'h00;
  assign dat_o      = we_o ? cmd_q[31:0] : 32'd0;
  assign busy_o     = state_q != IDLE;
  assign err_o      = err_q;
  assign err_code_o = code_q;
endmodule

// File: tb/tb_gfx_cmd_issuer.sv
// tb_gfx_cmd_issuer: directed vector table plus reset, timeout and streaming sequences
module tb_gfx_cmd_issuer;
  logic        clk = 1'b0, rst_i, cmd_valid_i, cmd_ready_o, cyc_o, stb_o, we_o, ack_i;
  logic [47:0] cmd_i;
  logic [7:0]  adr_o;
  logic [31:0] dat_o, dat_i;
  logic [3:0]  sel_o;
  logic        busy_o, err_o;
  logic [1:0]  err_code_o;
  gfx_cmd_issuer #(.POLL_GAP(8), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_i(cmd_i), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .sel_o(sel_o), .ack_i(ack_i), .dat_i(dat_i), .busy_o(busy_o), .err_o(err_o),
    .err_code_o(err_code_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [47:0] cmd;
    int lat, nbusy, exp_nwr, exp_nrd, exp_cyc;
    logic [7:0] exp_adr;
    logic [31:0] exp_dat;
    logic exp_err;
    logic [1:0] exp_code;
  } vec_t;
  vec_t vecs[8];
  int tests = 0, fails = 0;
  int lat = 1, cnt = 0, idle = 0, nrd = 0, cyc_cycles = 0, bad_bus = 0;
  logic busy_all = 1'b0, stray = 1'b0;
  logic stat[$];
  logic [39:0] wr_log[$];
  logic [39:0] first_wd;
  int gaps[$];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  // Wishbone slave: acks on the lat-th cycle of each transfer, logs writes and read gaps
  initial begin
    ack_i = 1'b0;
    dat_i = 32'd0;
    forever begin
      @(negedge clk);
      ack_i = 1'b0;
      if (cyc_o) begin
        if (sel_o != 4'hF || !stb_o) bad_bus++;
        if (cnt == 0) begin
          first_wd = {adr_o, dat_o};
          if (!we_o) gaps.push_back(idle);
        end
        if ({adr_o, dat_o} != first_wd) bad_bus++;
        idle = 0;
        cnt++;
        cyc_cycles++;
        if (cnt >= lat) begin
          ack_i = 1'b1;
          cnt = 0;
          if (we_o) wr_log.push_back({adr_o, dat_o});
          else begin
            nrd++;
            if (adr_o != 8'h04) bad_bus++;
            dat_i = {31'd0, stat.size() > 0 ? stat.pop_front() : busy_all};
          end
        end
      end else begin
        cnt = 0;
        idle++;
        if (sel_o != 4'h0) bad_bus++;
        ack_i = stray;
      end
    end
  end
  task automatic clear_log();
    wr_log.delete();
    gaps.delete();
    stat.delete();
    nrd = 0;
    cyc_cycles = 0;
    bad_bus = 0;
  endtask
  task automatic send(input logic [47:0] c);
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_i = c;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready_o) break;
      @(negedge clk);
    end
    chk("accept", cmd_ready_o, 1'b1);
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (!busy_o && cmd_ready_o) break;
      @(negedge clk);
    end
    chk("idle", {busy_o, cmd_ready_o}, 2'b01);
  endtask
  task automatic check_gaps(input string n, input logic draw);
    int bad = 0;
    for (int j = 0; j < gaps.size(); j++)
      if ((j > 0 || draw) && gaps[j] != 8) bad++;
    chk(n, bad, 0);
  endtask
  logic [47:0] s[3];
  int k, low_cnt, t;
  logic acc;
  initial begin
    vecs[0] = '{48'h01_10_0000_1000, 3, 0, 1, 0, 3, 8'h10, 32'h0000_1000, 1'b0, 2'd0};
    vecs[1] = '{48'h01_20_DEAD_BEEF, 1, 0, 1, 0, 1, 8'h20, 32'hDEAD_BEEF, 1'b0, 2'd0};
    vecs[2] = '{48'h03_55_0000_0100, 1, 2, 1, 3, 4, 8'h00, 32'h0000_0100, 1'b0, 2'd0};
    vecs[3] = '{48'h02_00_0000_0000, 2, 0, 0, 1, 2, 8'h00, 32'h0, 1'b0, 2'd0};
    vecs[4] = '{48'h02_04_0000_0000, 1, 1, 0, 2, 2, 8'h00, 32'h0, 1'b0, 2'd0};
    vecs[5] = '{48'h01_13_1234_5678, 1, 0, 0, 0, 0, 8'h00, 32'h0, 1'b1, 2'd2};
    vecs[6] = '{48'h7F_10_0000_0001, 1, 0, 0, 0, 0, 8'h00, 32'h0, 1'b1, 2'd2};
    vecs[7] = '{48'h01_0C_A5A5_A5A5, 2, 0, 1, 0, 2, 8'h0C, 32'hA5A5_A5A5, 1'b1, 2'd2};
    rst_i = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_i = '0;
    repeat (2) @(negedge clk);
    chk("rst ready", cmd_ready_o, 1'b0);
    chk("rst bus", {cyc_o, stb_o, we_o, sel_o, adr_o}, '0);
    chk("rst dat", dat_o, 32'd0);
    chk("rst status", {busy_o, err_o, err_code_o}, 4'd0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("ready after rst", cmd_ready_o, 1'b1);
    for (int i = 0; i < 8; i++) begin
      clear_log();
      lat = vecs[i].lat;
      for (int j = 0; j < vecs[i].nbusy; j++) stat.push_back(1'b1);
      stat.push_back(1'b0);
      send(vecs[i].cmd);
      wait_idle();
      chk($sformatf("v%0d nwr", i), wr_log.size(), vecs[i].exp_nwr);
      chk($sformatf("v%0d nrd", i), nrd, vecs[i].exp_nrd);
      chk($sformatf("v%0d cyc", i), cyc_cycles, vecs[i].exp_cyc);
      if (wr_log.size() > 0)
        chk($sformatf("v%0d wr", i), wr_log[0], {vecs[i].exp_adr, vecs[i].exp_dat});
      chk($sformatf("v%0d err", i), {err_o, err_code_o}, {vecs[i].exp_err, vecs[i].exp_code});
      chk($sformatf("v%0d bus", i), bad_bus, 0);
      check_gaps($sformatf("v%0d gap", i), vecs[i].cmd[47:40] == 8'h03);
    end
    // reset while a write waits for ack, then a stray ack while idle
    clear_log();
    lat = 1000;
    send(48'h01_30_CAFE_F00D);
    chk("pre-rst cyc", {cyc_o, we_o}, 2'b11);
    rst_i = 1'b1;
    @(negedge clk);
    chk("mid rst cyc", {cyc_o, stb_o, we_o, sel_o, adr_o}, '0);
    chk("mid rst dat", dat_o, 32'd0);
    chk("mid rst status", {cmd_ready_o, busy_o, err_o, err_code_o}, 5'd0);
    rst_i = 1'b0;
    lat = 1;
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray ack", {busy_o, cmd_ready_o, cyc_o}, 3'b010);
    chk("no replay", wr_log.size(), 0);
    send(48'h01_30_1234_5678);
    wait_idle();
    chk("post-rst nwr", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("post-rst wr", wr_log[0], {8'h30, 32'h1234_5678});
    // WAIT against a permanently busy engine hits the timeout after 4 reads
    clear_log();
    busy_all = 1'b1;
    send(48'h02_04_0000_0000);
    wait_idle();
    busy_all = 1'b0;
    chk("timeout nrd", nrd, 4);
    chk("timeout err", {err_o, err_code_o}, 3'b111);
    check_gaps("timeout gap", 1'b0);
    // three writes streamed with valid held high
    clear_log();
    s[0] = 48'h01_40_1111_1111;
    s[1] = 48'h01_44_2222_2222;
    s[2] = 48'h01_48_3333_3333;
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_i = s[0];
    k = 0;
    low_cnt = 0;
    for (t = 0; t < 60 && k < 3; t++) begin
      if (!cmd_ready_o) low_cnt++;
      if (cmd_ready_o && busy_o) bad_bus++;
      acc = cmd_ready_o;
      @(negedge clk);
      if (acc) begin
        k++;
        if (k < 3) cmd_i = s[k];
        else cmd_valid_i = 1'b0;
      end
    end
    wait_idle();
    chk("stream accepts", k, 3);
    chk("stream cycles", t, 5);
    chk("stream ready low", low_cnt, 2);
    chk("stream nwr", wr_log.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < wr_log.size()) chk($sformatf("stream wr%0d", i), wr_log[i], s[i][39:0]);
    chk("stream bus", bad_bus, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
